// File: rtl/d_input_debouncer.sv
// Synchronises and debounces a raw level; Q_o follows only after STABLE_CYCLES stable cycles.
// Define DEBOUNCE_EDGE_EN to build the registered Rise_o/Fall_o pulses (otherwise tied to 0).
module d_input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic C_i,
  input  logic nR_i,
  input  logic D_i,
  output logic Q_o,
  output logic nQ_o,
  output logic Rise_o,
  output logic Fall_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  logic             sync0_q, sync1_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic             q_q, q_d;
  logic             nq_q, nq_d;
  logic             accept;

  always_ff @(posedge C_i or negedge nR_i) begin
    if (!nR_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= D_i;
      sync1_q <= sync0_q;
    end
  end

  // Any cycle where the synchronised level matches Q_o discards the partial count.
  always_comb begin
    cnt_cur = (state_q == CHECK) ? cnt_q : '0;
    accept  = 1'b0;
    state_d = IDLE;
    cnt_d   = '0;
    q_d     = q_q;
    nq_d    = nq_q;
    if (sync1_q != q_q) begin
      if (cnt_cur == CNT_LAST) begin
        accept = 1'b1;
        q_d    = sync1_q;
        nq_d   = ~sync1_q;
      end else begin
        cnt_d   = cnt_cur + CNT_ONE;
        state_d = CHECK;
      end
    end
  end

  always_ff @(posedge C_i or negedge nR_i) begin
    if (!nR_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      nq_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      nq_q    <= nq_d;
    end
  end

  assign Q_o  = q_q;
  assign nQ_o = nq_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses line up with the cycle in which the new Q_o is first visible.
  always_ff @(posedge C_i or negedge nR_i) begin
    if (!nR_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync1_q;
      fall_q <= accept & ~sync1_q;
    end
  end

  assign Rise_o = rise_q;
  assign Fall_o = fall_q;
`else
  assign Rise_o = 1'b0;
  assign Fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Bench for d_input_debouncer: directed scenarios plus random input against a windowed reference model.
module tb_d_input_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic C_i  = 1'b0;
  logic nR_i = 1'b0;
  logic D_i  = 1'b0;
  logic Q_o, nQ_o, Rise_o, Fall_o;

  int n_cmp = 0;
  int n_bad = 0;

  d_input_debouncer #(.STABLE_CYCLES(SC)) dut (
    .C_i    (C_i),
    .nR_i   (nR_i),
    .D_i    (D_i),
    .Q_o    (Q_o),
    .nQ_o   (nQ_o),
    .Rise_o (Rise_o),
    .Fall_o (Fall_o)
  );

  always #2 C_i = ~C_i;

  // Reference: s is D_i as seen two edges earlier; Q flips once the last SC samples of s all differ from it.
  bit d_hist[$];
  bit s_hist[$];
  bit mq    = 1'b0;
  bit mrise = 1'b0;
  bit mfall = 1'b0;

  always @(posedge C_i or negedge nR_i) begin
    bit s;
    bit all_diff;
    if (!nR_i) begin
      d_hist = '{1'b0, 1'b0};
      s_hist = '{};
      mq = 1'b0; mrise = 1'b0; mfall = 1'b0;
    end else begin
      if (d_hist.size() < 2) d_hist = '{1'b0, 1'b0};
      s = d_hist[d_hist.size()-2];
      d_hist.push_back(D_i);
      if (d_hist.size() > 4) void'(d_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > SC) void'(s_hist.pop_front());
      mrise = 1'b0; mfall = 1'b0;
      all_diff = (s_hist.size() == SC);
      for (int i = 0; i < s_hist.size(); i++)
        if (s_hist[i] == mq) all_diff = 1'b0;
      if (all_diff) begin
        mq    = ~mq;
        mrise = EDGE_EN && mq;
        mfall = EDGE_EN && !mq;
        s_hist = '{};
      end
    end
  end

  task automatic test_reset();
    nR_i = 1'b0;
    D_i  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o, Rise_o, Fall_o} !== 4'b0100) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b required 0100", c, {Q_o, nQ_o, Rise_o, Fall_o});
      end
    end
    #1 D_i = 1'b0;
    nR_i = 1'b1;
    repeat (8) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o} !== 2'b01) begin
        n_bad++;
        $display("FAIL reset_idle: got %b required 01", {Q_o, nQ_o});
      end
    end
  endtask

  task automatic test_clean_rise();
    @(negedge C_i);
    #1 D_i = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o, Rise_o, Fall_o} !== {e >= 5, e < 5, EDGE_EN && e == 5, 1'b0}) begin
        n_bad++;
        $display("FAIL clean_rise edge %0d: got %b required %b", e, {Q_o, nQ_o, Rise_o, Fall_o},
                 {e >= 5, e < 5, EDGE_EN && e == 5, 1'b0});
      end
    end
  endtask

  task automatic test_clean_fall();
    @(negedge C_i);
    #1 D_i = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o, Rise_o, Fall_o} !== {e < 5, e >= 5, 1'b0, EDGE_EN && e == 5}) begin
        n_bad++;
        $display("FAIL clean_fall edge %0d: got %b required %b", e, {Q_o, nQ_o, Rise_o, Fall_o},
                 {e < 5, e >= 5, 1'b0, EDGE_EN && e == 5});
      end
    end
  endtask

  task automatic test_bounce();
    @(negedge C_i);
    fork
      begin
        #1 D_i = 1'b1;
        #2 D_i = 1'b0;
        #4 D_i = 1'b1;
        #4 D_i = 1'b0;
        #4 D_i = 1'b1;
        #8 D_i = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge C_i);
          n_cmp++;
          if ({Q_o, nQ_o, Rise_o} !== 3'b010 || Q_o !== mq) begin
            n_bad++;
            $display("FAIL bounce cyc %0d: got Q/nQ/Rise %b required 010 (model Q %b)",
                     c, {Q_o, nQ_o, Rise_o}, mq);
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_count();
    @(negedge C_i);
    #1 D_i = 1'b1;
    repeat (4) @(posedge C_i);
    #1 nR_i = 1'b0;
    #1;
    n_cmp++;
    if ({Q_o, nQ_o, Rise_o, Fall_o} !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_mid async: got %b required 0100", {Q_o, nQ_o, Rise_o, Fall_o});
    end
    #5 nR_i = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o, Rise_o, Fall_o} !== {e >= 5, e < 5, EDGE_EN && e == 5, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_mid edge %0d: got %b required %b", e, {Q_o, nQ_o, Rise_o, Fall_o},
                 {e >= 5, e < 5, EDGE_EN && e == 5, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    bit prev_pulse = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge C_i);
      n_cmp++;
      if ({Q_o, nQ_o, Rise_o, Fall_o} !== {mq, ~mq, mrise, mfall}) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %b required %b", c, {Q_o, nQ_o, Rise_o, Fall_o},
                 {mq, ~mq, mrise, mfall});
      end
      n_cmp++;
      if ((Rise_o && Fall_o) || (prev_pulse && (Rise_o || Fall_o))) begin
        n_bad++;
        $display("FAIL pulse_shape cyc %0d: got rise %b fall %b prev %b required isolated single pulse",
                 c, Rise_o, Fall_o, prev_pulse);
      end
      prev_pulse = Rise_o || Fall_o;
      if (hold == 0) begin
        #1 D_i = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_reset_mid_count();
    test_clean_fall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_input_debouncer.md
# d_input_debouncer

Input conditioning stage that sits directly upstream of the D flip-flop trigger. It takes a raw, asynchronous, possibly bouncing level, synchronises it to `C_i`, and accepts a new level only after it has been stable for a programmable number of cycles. It delivers a clean level `Q_o` and its complement `nQ_o` for the trigger's `D_i`. Optional one-cycle edge pulses report accepted transitions.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive clock cycles the synchronised input must differ from `Q_o` before `Q_o` follows it; legal range 1..65535.
- `C_i` input 1: clock; all state updates on the rising edge.
- `nR_i` input 1: reset, asynchronous, active-low.
- `D_i` input 1: raw asynchronous level.
- `Q_o` output 1: debounced level, registered.
- `nQ_o` output 1: always the complement of `Q_o`, registered.
- `Rise_o` output 1: one-cycle pulse when `Q_o` goes 0->1.
- `Fall_o` output 1: one-cycle pulse when `Q_o` goes 1->0.

## Operation
- Synchroniser: two flops, `sync0 <= D_i` and `sync1 <= sync0`. `s = sync1` is the only value the FSM reads.
- Counter `cnt` has width `$clog2(STABLE_CYCLES+1)` and saturates at no value; the FSM bounds it.
- FSM has two states:
  - IDLE: `s == Q_o`, `cnt == 0`.
  - CHECK: a candidate change is being timed.
- Per rising edge:
  - If `s == Q_o`: state <= IDLE, `cnt` <= 0. No output change. This covers glitch rejection: a return to the old level discards all progress.
  - If `s != Q_o` and `cnt == STABLE_CYCLES-1`: `Q_o` <= `s`, `nQ_o` <= `~s`, `cnt` <= 0, state <= IDLE. In the same edge, `Rise_o` <= `s` and `Fall_o` <= `~s`.
  - If `s != Q_o` otherwise: `cnt` <= `cnt+1`, state <= CHECK.
- `Rise_o`/`Fall_o` are 0 on every edge that does not update `Q_o`. They are never high together and never high for two consecutive cycles.
- When `STABLE_CYCLES=1`, the block degenerates to synchroniser plus one register stage. CHECK is never entered.
- Reset (`nR_i`=0, any time including mid-count) asynchronously clears:
  - `sync0`, `sync1`, `cnt`, `Rise_o` and `Fall_o` to 0;
  - state to IDLE;
  - `Q_o` to 0 and `nQ_o` to 1.
- Counting restarts from zero after reset release.

## Timing
- Reset values: `Q_o`=0, `nQ_o`=1, `Rise_o`=0, `Fall_o`=0.
- Latency: `D_i` changes before edge 0 and stays stable. Then `s` changes after edge 1, and `Q_o` changes after edge `STABLE_CYCLES+1` (edge 5 at the default).
- The edge pulse is high for exactly the cycle following the edge that updates `Q_o`, aligned with the new `Q_o`.
- Rejection threshold: any `s` excursion shorter than `STABLE_CYCLES` cycles leaves `Q_o` unchanged.
- `D_i` changes within a cycle of a clock edge may resolve either way in `sync0`. The resulting acceptance may shift by ±1 cycle, never more.
- With the default parameter and a 4 ns clock, the worst-case input-to-`Q_o` delay is 24 ns.

## Configuration
- Macro: `DEBOUNCE_EDGE_EN`.
- Defined: `Rise_o`/`Fall_o` are driven as described in Operation.
- Undefined: the edge-pulse registers are not built, and `Rise_o`/`Fall_o` are tied to constant 0. `Q_o`/`nQ_o` behaviour is identical in both builds.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and a 4 ns clock, with `DEBOUNCE_EDGE_EN` defined unless stated.
- Reset: `nR_i`=0 with `D_i`=1 -> `Q_o`=0, `nQ_o`=1, `Rise_o`=`Fall_o`=0, held for the whole reset.
- Clean rise: `D_i` 0->1 before edge 0, held -> `Q_o`=1 and `nQ_o`=0 after edge 5. `Rise_o`=1 for exactly one cycle after edge 5, 0 otherwise.
- Bounce: `D_i` pulses 1 for 2 ns, 4 ns and 8 ns, each separated by 4 ns low, then stays 0 -> `Q_o` stays 0 and `Rise_o` never asserts.
- Clean fall: from `Q_o`=1, `D_i` 1->0 held -> `Q_o`=0 after edge 5, `Fall_o` high one cycle, `Rise_o` stays 0.
- Reset mid-count: `D_i`=1 held, `nR_i` pulled low after edge 3 for 6 ns -> outputs return to reset values immediately. After release, `Q_o` rises at the 5th edge after release.
- Macro undefined: repeat clean rise and clean fall -> identical `Q_o`/`nQ_o` timing, `Rise_o`=`Fall_o`=0 throughout.
